data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-memory slave that services load/store requests issued by the CPU datapath over a valid/ready request channel and returns results on a valid/ready response channel.
- One outstanding transaction at a time.
- Programmable wait-state latency, so the CPU handshake logic can be exercised against slow memory.
- Sits beside the CPU top as the responder end of the core's memory interface.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width of the request.
- DEPTH, 1024, number of DATA_W-bit words stored.
- WAIT_CYC, 2, wait states between request accept and memory access; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_be  in  DATA_W/8  byte enables for a store; ignored on a load.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  DATA_W  load data; 0 for stores.
- resp_err  out  1  address error flag (see Optional Feature).

Behaviour:
- Reset values: FSM = IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/be. Go to WAIT with cnt=WAIT_CYC-1 if WAIT_CYC>0; otherwise do the access on this edge and go to RESP.
  - WAIT: req_ready=0. Decrement cnt each cycle. On the edge where cnt==0, perform the access and go to RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid&&resp_ready. On that edge: resp_valid→0, go to IDLE.
- Latency: resp_valid rises on the edge WAIT_CYC cycles after the accepting edge, so it is visible WAIT_CYC+1 cycles after the accept.
- Access on a load: resp_rdata ← mem[addr].
- Access on a store: for each byte lane i with be[i]=1, mem[addr] byte i ← wdata byte i; resp_rdata ← 0. A store with be=0 writes nothing but still responds.
- req_ready is driven from state only. It is low from the accept edge until the edge after the response handshake, so the earliest back-to-back accept is one cycle after the response handshake.
- resp_ready held high before resp_valid: the handshake completes on the first RESP cycle.
- Inputs during WAIT or RESP are ignored; the latched copies are used.
- Reset asserted mid-transaction:
  - Immediate return to IDLE.
  - A store not yet performed (still in WAIT) is dropped.
  - A store already performed is kept.
- Address mapping: word index = req_addr (word addressed).

Optional Feature:
- Macro: DMEM_BOUNDS_CHK_EN.
- Defined: a request with addr >= DEPTH completes with normal timing. Its response has resp_err=1 and resp_rdata=0, and memory is left unmodified.
- Undefined: resp_err is tied 0. The index is addr modulo DEPTH (low $clog2(DEPTH) bits), so out-of-range addresses alias.

Decomposition:
- Shared package additions:
  - mem_state_e enum {IDLE, WAIT, RESP}.
  - mem_req_t struct {we, addr, wdata, be}.
  - Constant DMEM_DEPTH_DEF = 1024.
- Sub-module dmem_array: synchronous single-port byte-enabled RAM (DEPTH×DATA_W, one access per cycle).
- data_mem_responder holds the FSM, wait counter, request latch and response register.

Test Plan:
- Reset, then store addr=0x0010 wdata=0xBEEF be=2'b11 with WAIT_CYC=2: req_ready drops after accept; resp_valid rises 3 cycles after accept with rdata=0, err=0.
- Load addr=0x0010 after the above: resp_rdata=0xBEEF.
- Partial store addr=0x0010 wdata=0x1234 be=2'b01, then load: rdata=0xBE34.
- resp_ready held 0 for 5 cycles in RESP: resp_valid and rdata remain stable; no new request is accepted while req_valid=1. After resp_ready, req_ready returns one cycle later.
- WAIT_CYC=0 build: load accepted at edge E; resp_valid high in the cycle after E with correct data.
- Address 0x0400:
  - With DMEM_BOUNDS_CHK_EN defined, a store then load returns err=1, rdata=0, and mem[0] is unchanged.
  - Without it, the same address aliases to 0x0000 and err=0.
- Assert rst_n mid-WAIT of a store to 0x0020: FSM is IDLE and req_ready=1 immediately; a subsequent load of 0x0020 returns its prior value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// Optional feature macro: DMEM_BOUNDS_CHK_EN (out-of-range address flagging).
package data_mem_responder_pkg;

    localparam int DMEM_DEPTH_DEF  = 1024;
    localparam int DMEM_DATA_W_DEF = 16;
    localparam int DMEM_ADDR_W_DEF = 16;
    localparam int DMEM_BE_W_DEF   = DMEM_DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Latched request; field widths follow the package default geometry.
    typedef struct packed {
        logic                       we;
        logic [DMEM_ADDR_W_DEF-1:0] addr;
        logic [DMEM_DATA_W_DEF-1:0] wdata;
        logic [DMEM_BE_W_DEF-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the CPU datapath (master) and the
// data-memory responder (slave). Both channels use valid/ready handshakes.
// Optional feature macro: DMEM_BOUNDS_CHK_EN (drives resp_err when defined).
interface data_mem_responder_if
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W_DEF,
    parameter int ADDR_W = DMEM_ADDR_W_DEF
);
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Synchronous single-port byte-enabled RAM, DEPTH x DATA_W.
// One access per enabled cycle: a write merges enabled byte lanes, a read
// registers the addressed word; rdata holds between reads.
// Optional feature macro: DMEM_BOUNDS_CHK_EN (not used in this file).
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [IDX_W-1:0]    addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);
    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Single-port access: byte-lane write or registered read.
    // NOTE: the storage array has no reset branch; resetting a RAM forces it
    // into flops, and its contents are meant to survive a responder reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYC
// cycles, performs the RAM access, then presents the result until the
// initiator takes it.
// Optional feature macro: DMEM_BOUNDS_CHK_EN -- when defined, addresses
// >= DEPTH respond with resp_err=1, rdata=0 and no write; when undefined,
// resp_err is 0 and the address wraps onto the low index bits.
// DATA_W/ADDR_W must match the package defaults that size mem_req_t.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W   = DMEM_DATA_W_DEF,
    parameter int ADDR_W   = DMEM_ADDR_W_DEF,
    parameter int DEPTH    = DMEM_DEPTH_DEF,
    parameter int WAIT_CYC = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    data_mem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    mem_state_e        state;
    mem_state_e        nextState;
    logic [CNT_W-1:0]  cnt;
    mem_req_t          reqLatch;
    mem_req_t          incoming;
    mem_req_t          curReq;
    logic              accept;
    logic              doAccess;
    logic              inRange;
    logic              respIsLoad;
    logic [DATA_W-1:0] ramRdata;

    // Request decode: which request is being serviced and whether the RAM
    // is touched on the coming edge.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        incoming = '{we:    bus.req_we,
                     addr:  bus.req_addr,
                     wdata: bus.req_wdata,
                     be:    bus.req_be};
        // In IDLE the zero-wait access uses the live request, later states
        // use the latched copy so input changes are ignored.
        curReq   = (state == IDLE) ? incoming : reqLatch;
        accept   = (state == IDLE) && bus.req_valid;
        doAccess = (accept && (WAIT_CYC == 0)) ||
                   ((state == WAIT) && (cnt == '0));
`ifdef DMEM_BOUNDS_CHK_EN
        inRange  = ({1'b0, curReq.addr} < (ADDR_W + 1)'(DEPTH));
`else
        inRange  = 1'b1;
`endif
    end

`ifndef DMEM_BOUNDS_CHK_EN
    // High address bits are deliberately dropped: out-of-range addresses alias.
    logic unusedAddrBits;
    assign unusedAddrBits = ^curReq.addr[ADDR_W-1:IDX_W];
`endif

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_dmem_array (
        .clk   (clk),
        .en    (doAccess && inRange),
        .we    (curReq.we),
        .addr  (curReq.addr[IDX_W-1:0]),
        .wdata (curReq.wdata),
        .be    (curReq.be),
        .rdata (ramRdata)
    );

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state: accept -> wait states -> response until handshake.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) nextState = (WAIT_CYC == 0) ? RESP : WAIT;
            WAIT: if (cnt == '0) nextState = RESP;
            RESP: if (bus.resp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqLatch <= '0;
            cnt      <= '0;
        end else if (accept) begin
            reqLatch <= incoming;
            cnt      <= (WAIT_CYC == 0) ? '0 : CNT_W'(WAIT_CYC - 1);
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Response register: remembers whether the RAM output is load data.
    // The RAM output itself holds while in RESP because no access occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            respIsLoad <= 1'b0;
        end else if (doAccess) begin
            respIsLoad <= !curReq.we && inRange;
        end
    end

`ifdef DMEM_BOUNDS_CHK_EN
    logic respErrQ;

    // Error flag captured with the access, held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            respErrQ <= 1'b0;
        end else if (doAccess) begin
            respErrQ <= !inRange;
        end
    end

    assign bus.resp_err = respErrQ;
`else
    assign bus.resp_err = 1'b0;
`endif

    // Handshake outputs come from state only; rdata is zero for stores.
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = respIsLoad ? ramRdata : '0;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one DUT with two wait states
// and one with zero wait states, checked against a byte-level memory model.
// Honours DMEM_BOUNDS_CHK_EN when computing expected responses.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mdl   [2][DEPTH];
    logic [1:0]  known [2][DEPTH];

    always #5 clk = ~clk;

    data_mem_responder_if #(.DATA_W(16), .ADDR_W(16)) busA ();
    data_mem_responder_if #(.DATA_W(16), .ADDR_W(16)) busZ ();

    data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(0)) dutZ (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busZ)
    );

    function automatic logic rv(input bit z);
        return z ? busZ.resp_valid : busA.resp_valid;
    endfunction
    function automatic logic rq(input bit z);
        return z ? busZ.req_ready : busA.req_ready;
    endfunction
    function automatic logic [15:0] rd(input bit z);
        return z ? busZ.resp_rdata : busA.resp_rdata;
    endfunction
    function automatic logic re(input bit z);
        return z ? busZ.resp_err : busA.resp_err;
    endfunction

    task automatic drive(input bit z, input logic v, input logic we, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] b, input logic rr);
        if (z) begin
            busZ.req_valid = v; busZ.req_we = we; busZ.req_addr = a;
            busZ.req_wdata = d; busZ.req_be = b; busZ.resp_ready = rr;
        end else begin
            busA.req_valid = v; busA.req_we = we; busA.req_addr = a;
            busA.req_wdata = d; busA.req_be = b; busA.resp_ready = rr;
        end
    endtask

    task automatic drive_junk(input bit z, input logic v, input logic rr);
        logic [15:0] ja = 16'($urandom);
        logic [15:0] jd = 16'($urandom);
        logic [1:0]  jb = 2'($urandom);
        logic        jw = 1'($urandom);
        drive(z, v, jw, ja, jd, jb, rr);
    endtask

    // Reference: word-addressed memory, byte-lane stores, loads return the
    // stored word, out-of-range addresses error (bounds build) or wrap.
    task automatic model(input bit z, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be,
                         output logic [15:0] expData, output logic [15:0] mask,
                         output logic expErr);
        int k = int'(addr) % DEPTH;
        bit outside = 1'b0;
`ifdef DMEM_BOUNDS_CHK_EN
        outside = (int'(addr) >= DEPTH);
`endif
        expData = 16'h0000;
        mask    = 16'hFFFF;
        expErr  = outside;
        if (outside) return;
        if (we) begin
            for (int i = 0; i < 2; i++) begin
                if (be[i]) begin
                    mdl[z][k][8*i +: 8] = wdata[8*i +: 8];
                    known[z][k][i] = 1'b1;
                end
            end
        end else begin
            expData = mdl[z][k];
            mask    = {{8{known[z][k][1]}}, {8{known[z][k][0]}}};
        end
    endtask

    // One full transaction starting at a negedge in IDLE; returns at the
    // negedge after the response handshake with the inputs idle.
    task automatic txn(input bit z, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be,
                       input int hold, input bit busyValid, input string tag,
                       output logic [15:0] gotData);
        logic [15:0] expData, mask;
        logic        expErr, gotErr;
        int          lat;
        int          expLat = z ? 1 : 3;
        model(z, we, addr, wdata, be, expData, mask, expErr);
        checks++;
        if (rq(z) !== 1'b1) begin
            errors++; $display("FAIL %s req_ready_idle: got %b want 1", tag, rq(z));
        end
        drive(z, 1'b1, we, addr, wdata, be, hold == 0);
        @(negedge clk);
        drive_junk(z, busyValid, hold == 0);
        lat = 1;
        checks++;
        if (rq(z) !== 1'b0) begin
            errors++; $display("FAIL %s req_ready_busy: got %b want 0", tag, rq(z));
        end
        while (rv(z) !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != expLat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, expLat);
        end
        gotData = rd(z);
        gotErr  = re(z);
        checks++;
        if ((gotData & mask) !== (expData & mask)) begin
            errors++; $display("FAIL %s rdata: got %h want %h", tag, gotData, expData);
        end
        checks++;
        if (gotErr !== expErr) begin
            errors++; $display("FAIL %s resp_err: got %b want %b", tag, gotErr, expErr);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (rv(z) !== 1'b1 || rd(z) !== gotData || re(z) !== gotErr || rq(z) !== 1'b0) begin
                errors++;
                $display("FAIL %s hold_stable: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                         tag, rv(z), rd(z), re(z), rq(z), gotData, gotErr);
            end
            if (i == hold - 1) drive_junk(z, busyValid, 1'b1);
        end
        @(negedge clk);
        drive(z, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        checks++;
        if (rv(z) !== 1'b0 || rq(z) !== 1'b1) begin
            errors++;
            $display("FAIL %s after_handshake: got valid=%b ready=%b want valid=0 ready=1",
                     tag, rv(z), rq(z));
        end
    endtask

    task automatic test_reset();
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rq(z[0]) !== 1'b1 || rv(z[0]) !== 1'b0 || rd(z[0]) !== 16'h0 || re(z[0]) !== 1'b0) begin
                errors++;
                $display("FAIL reset_state%0d: got rdy=%b v=%b d=%h e=%b want rdy=1 v=0 d=0000 e=0",
                         z, rq(z[0]), rv(z[0]), rd(z[0]), re(z[0]));
            end
        end
    endtask

    task automatic test_store_load();
        logic [15:0] got;
        txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 0, 1'b0, "store_full", got);
        checks++;
        if (got !== 16'h0000) begin
            errors++; $display("FAIL store_rdata_zero: got %h want 0000", got);
        end
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 2'b00, 0, 1'b0, "load_full", got);
        checks++;
        if (got !== 16'hBEEF) begin
            errors++; $display("FAIL load_beef: got %h want beef", got);
        end
        txn(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01, 0, 1'b0, "store_partial", got);
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 2'b11, 0, 1'b0, "load_partial", got);
        checks++;
        if (got !== 16'hBE34) begin
            errors++; $display("FAIL load_be34: got %h want be34", got);
        end
        txn(1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, 0, 1'b0, "store_be0", got);
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 2'b00, 0, 1'b0, "load_after_be0", got);
    endtask

    task automatic test_backpressure();
        logic [15:0] got;
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 2'b00, 5, 1'b1, "load_stall5", got);
        txn(1'b0, 1'b1, 16'h0011, 16'hA5C3, 2'b11, 3, 1'b1, "store_stall3", got);
        txn(1'b0, 1'b0, 16'h0011, 16'h0000, 2'b00, 0, 1'b0, "load_b2b", got);
    endtask

    task automatic test_zero_wait();
        logic [15:0] got;
        txn(1'b1, 1'b1, 16'h0033, 16'h7E81, 2'b11, 0, 1'b0, "z_store", got);
        txn(1'b1, 1'b0, 16'h0033, 16'h0000, 2'b00, 0, 1'b0, "z_load", got);
        checks++;
        if (got !== 16'h7E81) begin
            errors++; $display("FAIL z_load_value: got %h want 7e81", got);
        end
        txn(1'b1, 1'b1, 16'h0033, 16'h00CC, 2'b10, 2, 1'b1, "z_store_hi", got);
        txn(1'b1, 1'b0, 16'h0033, 16'h0000, 2'b00, 2, 1'b1, "z_load_hi", got);
    endtask

    task automatic test_bounds();
        logic [15:0] got;
        txn(1'b0, 1'b1, 16'h0000, 16'h5A5A, 2'b11, 0, 1'b0, "pre_mem0", got);
        txn(1'b0, 1'b1, 16'h0400, 16'hC3C3, 2'b11, 0, 1'b0, "store_0400", got);
        txn(1'b0, 1'b0, 16'h0400, 16'h0000, 2'b00, 0, 1'b0, "load_0400", got);
        txn(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 0, 1'b0, "load_mem0", got);
`ifdef DMEM_BOUNDS_CHK_EN
        checks++;
        if (got !== 16'h5A5A) begin
            errors++; $display("FAIL mem0_untouched: got %h want 5a5a", got);
        end
`else
        checks++;
        if (got !== 16'hC3C3) begin
            errors++; $display("FAIL mem0_aliased: got %h want c3c3", got);
        end
`endif
    endtask

    task automatic test_reset_mid_txn();
        logic [15:0] got;
        logic [15:0] dummyData, dummyMask;
        logic        dummyErr;
        txn(1'b0, 1'b1, 16'h0020, 16'h1111, 2'b11, 0, 1'b0, "pre_0020", got);
        // Store to 0x0020 interrupted while waiting: must be dropped.
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h2222, 2'b11, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rq(1'b0) !== 1'b1 || rv(1'b0) !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: got rdy=%b v=%b want rdy=1 v=0", rq(1'b0), rv(1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 1'b0, 16'h0020, 16'h0000, 2'b00, 0, 1'b0, "load_after_drop", got);
        checks++;
        if (got !== 16'h1111) begin
            errors++; $display("FAIL store_dropped: got %h want 1111", got);
        end
        // Store already performed before reset: must be kept.
        model(1'b0, 1'b1, 16'h0020, 16'h3333, 2'b11, dummyData, dummyMask, dummyErr);
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h3333, 2'b11, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rq(1'b0) !== 1'b1 || rv(1'b0) !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_resp: got rdy=%b v=%b want rdy=1 v=0", rq(1'b0), rv(1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 1'b0, 16'h0020, 16'h0000, 2'b00, 0, 1'b0, "load_after_kept", got);
        checks++;
        if (got !== 16'h3333) begin
            errors++; $display("FAIL store_kept: got %h want 3333", got);
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [10] = '{16'h0000, 16'h0001, 16'h0010, 16'h0020, 16'h0155,
                                   16'h03FF, 16'h0400, 16'h0401, 16'h07FF, 16'hFFFF};
        logic [15:0] got;
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 10; i++) begin
                txn(z[0], 1'b1, pool[i], 16'($urandom), 2'b11, 0, 1'b0, "rnd_init", got);
            end
            for (int n = 0; n < 50; n++) begin
                txn(z[0], 1'($urandom), pool[$urandom_range(0, 9)], 16'($urandom),
                    2'($urandom), $urandom_range(0, 3), 1'($urandom), "rnd", got);
            end
        end
    endtask

    initial begin
        for (int z = 0; z < 2; z++) begin
            for (int k = 0; k < DEPTH; k++) begin
                mdl[z][k]   = 16'h0000;
                known[z][k] = 2'b00;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_store_load();
        test_backpressure();
        test_zero_wait();
        test_bounds();
        test_reset_mid_txn();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
